// File: rtl/mips_bp_pkg.sv
// Shared types for the fetch PC predictor: 2-bit counter encodings,
// the BTB entry layout and the saturating counter step.
package mips_bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Widest PC the entry layout can hold; narrower PCs are zero-extended.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] tag;
        logic [MAX_W-1:0] target;
        ctr_e             ctr;
    } btbEntry_t;

    function automatic ctr_e ctrStep(input ctr_e c, input logic taken);
        ctr_e n;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            default: n = taken ? ST  : WT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// registered update from the decode-side resolution.
module bp_btb
    import mips_bp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:2] lookupPc,
    output logic             predTaken,
    output logic [WIDTH-1:0] predTarget,
    input  logic             updEn,
    input  logic             updBranch,
    input  logic             updTaken,
    input  logic [WIDTH-1:2] updPc,
    input  logic [WIDTH-1:0] updTarget
);

    localparam int IW = $clog2(DEPTH);
    localparam int TW = WIDTH - IW - 2;

    btbEntry_t btb [DEPTH];

    logic [IW-1:0] lkIdx;
    logic [IW-1:0] upIdx;
    logic [TW-1:0] lkTag;
    logic [TW-1:0] upTag;
    logic          lkHit;
    logic          upHit;

    assign lkIdx = lookupPc[IW+1:2];
    assign lkTag = lookupPc[WIDTH-1:IW+2];
    assign upIdx = updPc[IW+1:2];
    assign upTag = updPc[WIDTH-1:IW+2];

    assign lkHit = btb[lkIdx].valid && (btb[lkIdx].tag == MAX_W'(lkTag));
    assign upHit = btb[upIdx].valid && (btb[upIdx].tag == MAX_W'(upTag));

    assign predTaken  = lkHit && btb[lkIdx].ctr[1];
    assign predTarget = btb[lkIdx].target[WIDTH-1:0];

    // Writes land at the edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (updEn) begin
            if (updBranch && upHit) begin
                btb[upIdx].ctr <= ctrStep(btb[upIdx].ctr, updTaken);
                if (updTaken) begin
                    btb[upIdx].target <= MAX_W'(updTarget);
                end
            end else if (updBranch && updTaken) begin
                btb[upIdx] <= '{valid: 1'b1,
                                tag: MAX_W'(upTag),
                                target: MAX_W'(updTarget),
                                ctr: WT};
            end else if (!updBranch && upHit) begin
                btb[upIdx].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB prediction and decode-side redirect.
// Define PERF_CNT_EN to build the branch/mispredict counters.
module pc_predict_unit
    import mips_bp_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchD,
    input  logic             TakenD,
    input  logic [WIDTH-1:0] TargetD,
    output logic [WIDTH-1:0] PCF,
    output logic             PredTakenF,
    output logic             RedirectD,
    output logic [31:0]      BranchCount,
    output logic [31:0]      MispredictCount
);

    logic [WIDTH-1:0] predTarget;
    logic [WIDTH-1:0] predNextF;
    logic             validD;
    logic [WIDTH-1:0] pcD;
    logic [WIDTH-1:0] predNextD;
    logic             resolveD;
    logic [WIDTH-1:0] correctNext;

    bp_btb #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) uBtb (
        .clk       (clk),
        .reset     (reset),
        .lookupPc  (PCF[WIDTH-1:2]),
        .predTaken (PredTakenF),
        .predTarget(predTarget),
        .updEn     (resolveD),
        .updBranch (BranchD),
        .updTaken  (TakenD),
        .updPc     (pcD[WIDTH-1:2]),
        .updTarget (TargetD)
    );

    assign predNextF   = PredTakenF ? predTarget : PCF + WIDTH'(4);
    assign resolveD    = validD && !StallD;
    assign correctNext = (BranchD && TakenD) ? TargetD : pcD + WIDTH'(4);
    assign RedirectD   = resolveD && (correctNext != predNextD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (RedirectD) begin
            PCF <= correctNext;
        end else if (!StallF) begin
            PCF <= predNextF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validD    <= 1'b0;
            pcD       <= '0;
            predNextD <= '0;
        end else if (FlushD || RedirectD) begin
            validD <= 1'b0;
        end else if (!StallD) begin
            validD    <= 1'b1;
            pcD       <= PCF;
            predNextD <= predNextF;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else begin
            if (resolveD && BranchD) begin
                BranchCount <= BranchCount + 32'd1;
            end
            if (RedirectD) begin
                MispredictCount <= MispredictCount + 32'd1;
            end
        end
    end
`else
    assign BranchCount     = '0;
    assign MispredictCount = '0;
`endif

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: each cycle's expected outputs are
// queued by the stimulus and checked by a negedge monitor.
module tb_pc_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic        BranchD, TakenD;
    logic [31:0] TargetD;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic        RedirectD;
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

`ifdef PERF_CNT_EN
    localparam logic [31:0] EXP_BC = 32'd20;
    localparam logic [31:0] EXP_MC = 32'd14;
`else
    localparam logic [31:0] EXP_BC = 32'd0;
    localparam logic [31:0] EXP_MC = 32'd0;
`endif

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        pt;
        logic        rd;
        bit          cnt;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];
    int   nPass  = 0;
    int   nTotal = 0;

    pc_predict_unit #(
        .WIDTH   (32),
        .DEPTH   (16),
        .RESET_PC(32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .StallF         (StallF),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .BranchD        (BranchD),
        .TakenD         (TakenD),
        .TargetD        (TargetD),
        .PCF            (PCF),
        .PredTakenF     (PredTakenF),
        .RedirectD      (RedirectD),
        .BranchCount    (BranchCount),
        .MispredictCount(MispredictCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                     nm, id, act, exp);
        end
    endtask

    task automatic expect_out(input int id, input logic [31:0] pc,
                              input logic pt, input logic rd,
                              input bit cnt, input logic [31:0] bc,
                              input logic [31:0] mc);
        exp_t e;
        e.id  = id;
        e.pc  = pc;
        e.pt  = pt;
        e.rd  = rd;
        e.cnt = cnt;
        e.bc  = bc;
        e.mc  = mc;
        q.push_back(e);
    endtask

    task automatic step(input int id, input logic sf, input logic sd,
                        input logic fd, input logic br, input logic tk,
                        input logic [31:0] tgt, input logic [31:0] pc,
                        input logic pt, input logic rd, input bit cnt = 0);
        StallF  = sf;
        StallD  = sd;
        FlushD  = fd;
        BranchD = br;
        TakenD  = tk;
        TargetD = tgt;
        expect_out(id, pc, pt, rd, cnt, EXP_BC, EXP_MC);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one queued expectation per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("PCF", e.id, PCF, e.pc);
                chk("PredTakenF", e.id, 32'(PredTakenF), 32'(e.pt));
                chk("RedirectD", e.id, 32'(RedirectD), 32'(e.rd));
                if (e.cnt) begin
                    chk("BranchCount", e.id, BranchCount, e.bc);
                    chk("MispredictCount", e.id, MispredictCount, e.mc);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        StallF  = 1'b0;
        StallD  = 1'b0;
        FlushD  = 1'b0;
        BranchD = 1'b0;
        TakenD  = 1'b0;
        TargetD = 32'h0;
        @(posedge clk);
        #1;
        BranchD = 1'b1;
        TakenD  = 1'b1;
        TargetD = 32'h100;
        expect_out(-1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // id sf sd fd br tk target       pc         pt rd
        step( 0, 0, 0, 0, 0, 0, 32'h0,   32'h00, 0, 0);
        step( 1, 0, 0, 0, 0, 0, 32'h0,   32'h04, 0, 0);
        step( 2, 0, 0, 0, 0, 0, 32'h0,   32'h08, 0, 0);
        step( 3, 0, 0, 0, 0, 0, 32'h0,   32'h0C, 0, 0);
        step( 4, 0, 0, 0, 0, 0, 32'h0,   32'h10, 0, 0);
        step( 5, 0, 0, 0, 1, 1, 32'h40,  32'h14, 0, 1);
        step( 6, 0, 0, 0, 0, 0, 32'h0,   32'h40, 0, 0);
        step( 7, 0, 0, 0, 1, 1, 32'h10,  32'h44, 0, 1);
        step( 8, 0, 0, 0, 0, 0, 32'h0,   32'h10, 1, 0);
        step( 9, 0, 0, 0, 1, 1, 32'h40,  32'h40, 1, 0);
        step(10, 0, 0, 0, 1, 1, 32'h10,  32'h10, 1, 0);
        step(11, 0, 0, 0, 1, 0, 32'h0,   32'h40, 1, 1);
        step(12, 0, 0, 0, 0, 0, 32'h0,   32'h14, 0, 0);
        step(13, 0, 0, 0, 1, 1, 32'h10,  32'h18, 0, 1);
        step(14, 0, 0, 0, 0, 0, 32'h0,   32'h10, 1, 0);
        step(15, 0, 0, 0, 1, 0, 32'h0,   32'h40, 1, 1);
        step(16, 0, 0, 0, 0, 0, 32'h0,   32'h14, 1, 0);
        step(17, 0, 0, 0, 1, 1, 32'h10,  32'h10, 0, 0);
        step(18, 0, 0, 0, 1, 0, 32'h0,   32'h14, 1, 0);
        step(19, 0, 0, 0, 1, 1, 32'h10,  32'h10, 0, 0);
        step(20, 0, 0, 0, 1, 0, 32'h0,   32'h14, 1, 0);
        step(21, 0, 0, 0, 1, 1, 32'h10,  32'h10, 0, 0);
        step(22, 0, 0, 0, 1, 1, 32'h50,  32'h14, 1, 1);
        step(23, 0, 0, 0, 0, 0, 32'h0,   32'h50, 0, 0);
        step(24, 0, 0, 0, 0, 0, 32'h0,   32'h54, 0, 0);
        step(25, 0, 0, 0, 1, 1, 32'h10,  32'h58, 0, 1);
        step(26, 0, 0, 0, 0, 0, 32'h0,   32'h10, 0, 0);
        step(27, 0, 0, 0, 1, 1, 32'h50,  32'h14, 0, 1);
        step(28, 0, 0, 0, 0, 0, 32'h0,   32'h50, 0, 0);
        step(29, 0, 0, 0, 0, 0, 32'h0,   32'h54, 1, 0);
        step(30, 0, 0, 0, 1, 1, 32'h10,  32'h10, 1, 0);
        step(31, 0, 0, 0, 0, 0, 32'h0,   32'h50, 0, 1);
        step(32, 0, 0, 0, 0, 0, 32'h0,   32'h14, 0, 0);
        step(33, 0, 0, 0, 1, 1, 32'h10,  32'h18, 0, 1);
        step(34, 0, 0, 0, 0, 0, 32'h0,   32'h10, 0, 0);
        step(35, 1, 0, 0, 1, 1, 32'h80,  32'h14, 1, 1);
        step(36, 0, 0, 0, 0, 0, 32'h0,   32'h80, 0, 0);
        step(37, 1, 1, 0, 1, 1, 32'h20,  32'h84, 0, 0);
        step(38, 1, 1, 0, 1, 1, 32'h20,  32'h84, 0, 0);
        step(39, 0, 0, 0, 1, 1, 32'h20,  32'h84, 0, 1);
        step(40, 0, 0, 0, 0, 0, 32'h0,   32'h20, 0, 0);
        step(41, 0, 0, 0, 1, 1, 32'h80,  32'h24, 0, 1);
        step(42, 0, 0, 0, 0, 0, 32'h0,   32'h80, 1, 0);
        step(43, 0, 0, 0, 0, 0, 32'h0,   32'h20, 1, 1);
        step(44, 0, 0, 0, 0, 0, 32'h0,   32'h84, 0, 0);
        step(45, 0, 0, 1, 0, 0, 32'h0,   32'h88, 0, 0);
        step(46, 0, 0, 0, 1, 1, 32'h200, 32'h8C, 0, 0);
        step(47, 0, 0, 0, 0, 0, 32'h0,   32'h90, 0, 0, 1);

        // Mid-run reset with a would-be mispredict sitting in decode.
        BranchD = 1'b1;
        TakenD  = 1'b1;
        TargetD = 32'h300;
        #1;
        reset = 1'b1;
        expect_out(100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        BranchD = 1'b0;
        TakenD  = 1'b0;
        TargetD = 32'h0;
        // 0x10 must miss: the pre-reset BTB entry for it is gone.
        step(101, 0, 0, 0, 0, 0, 32'h0, 32'h00, 0, 0);
        expect_out(102, 32'h04, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        step(103, 0, 0, 0, 0, 0, 32'h0, 32'h08, 0, 0);
        step(104, 0, 0, 0, 0, 0, 32'h0, 32'h0C, 0, 0);
        step(105, 0, 0, 0, 0, 0, 32'h0, 32'h10, 0, 0);

        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            nTotal++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/pc_predict_unit.md
PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/target width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, BTB entries; power of two, 4..256.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports:
  clk  in  1  clock;
  reset  in  1  async active-high reset;
  StallF  in  1  hold PCF;
  StallD  in  1  hold decode-side record;
  FlushD  in  1  invalidate decode-side record;
  BranchD  in  1  instruction in D is a branch/jump;
  TakenD  in  1  resolved direction;
  TargetD  in  WIDTH  resolved target;
  PCF  out  WIDTH  fetch PC;
  PredTakenF  out  1  BTB predicts taken for PCF;
  RedirectD  out  1  mispredict, core flushes its F/D register;
  BranchCount  out  32  resolved branches;
  MispredictCount  out  32  redirects.

Function
REQ-006 SHALL look up the BTB combinationally on PCF: index = PCF[log2(DEPTH)+1:2], tag = PCF[WIDTH-1:log2(DEPTH)+2]; entry = {valid, tag, target, 2-bit counter}.
REQ-007 PredTakenF SHALL be valid & tag match & counter[1]; predicted next = PredTakenF ? entry target : PCF+4, modulo 2^WIDTH.
REQ-008 SHALL keep an internal D record {validD, PCD, PredNextD} loaded from F when ~StallD; cleared by FlushD or RedirectD; held when StallD.
REQ-009 Resolution occurs only when validD & ~StallD; correct next = (BranchD & TakenD) ? TargetD : PCD+4.
REQ-010 RedirectD SHALL be asserted combinationally in the resolution cycle iff correct next != PredNextD; zero otherwise.
REQ-011 PCF next-value priority: RedirectD -> correct next (overrides StallF); else StallF -> hold; else predicted next.
REQ-012 BTB update at resolution, BranchD=1, hit: counter saturating +1 if taken, -1 if not; target := TargetD if taken.
REQ-013 BTB update at resolution, BranchD=1, miss: taken -> allocate {valid, tag, TargetD, 2'b10}; not taken -> no write.
REQ-014 BTB update at resolution, BranchD=0 with tag hit: clear that entry's valid.
REQ-015 Same-cycle lookup and update of one index SHALL return the pre-update entry; update visible next cycle.
REQ-016 Counters SHALL saturate at 2'b00 and 2'b11; never wrap.

Reset
REQ-017 On reset: PCF=RESET_PC, validD=0, all BTB valid=0, all counters=2'b01, counts=0; RedirectD=0 and PredTakenF=0 while reset is high.
REQ-018 Reset asserted mid-operation SHALL discard in-flight prediction; the first fetch after release is RESET_PC.

Configuration
REQ-019 Macro PERF_CNT_EN defined: BranchCount increments per resolution with BranchD=1, MispredictCount per RedirectD cycle, both wrap at 2^32.
REQ-020 Macro PERF_CNT_EN undefined: counter logic SHALL be absent; both ports tied to 0.

Structure
REQ-021 Package mips_bp_pkg SHALL hold counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the BTB entry typedef.
REQ-022 BTB storage and update logic SHALL be sub-module bp_btb; PC register, D record, redirect and counters stay in pc_predict_unit.

Verification (WIDTH=32, DEPTH=16, RESET_PC=0)
REQ-023 Release reset, no branches -> PCF 0x0, 0x4, 0x8 on successive cycles; PredTakenF=0; RedirectD=0.
REQ-024 Taken branch at 0x10 to 0x40 -> RedirectD=1 for one cycle, PCF=0x40 next cycle, entry allocated WT; refetch of 0x10 -> PredTakenF=1, next PCF=0x40, no redirect.
REQ-025 Branch at 0x10 resolved not-taken twice after allocation -> first resolution redirects to 0x14, counter WT->WNT->SNT; third fetch of 0x10 predicts not taken.
REQ-026 Fetch 0x50 (same index as 0x10, different tag) -> miss, PredTakenF=0; non-branch resolved at 0x10 with hit -> redirect to 0x14, entry invalidated.
REQ-027 Redirect while StallF=1 -> PCF loads correct target; BranchD with StallD=1 -> no redirect and no BTB write until StallD falls.
REQ-028 PERF_CNT_EN defined, 5 branches with 2 mispredicts -> BranchCount=5, MispredictCount=2; macro undefined -> both 0.
